// File: rtl/rr_pkg.sv
// Shared definitions for the round-robin request manager.
// Holds the default channel count, pending-count width, starvation threshold
// and the 16-bit wait-count type used by the channel and top modules.
package rr_pkg;

  localparam int unsigned ReqCntDefault    = 16;
  localparam int unsigned PendWDefault     = 4;
  localparam int unsigned WaitLimitDefault = 64;

  typedef logic [15:0] wait_cnt_t;

endpackage

// File: rtl/rr_req_chan.sv
// One requester channel: pending-request counter, wait counter, starvation flag.
// Ports:
//   clk_i, rst_n_i   clock, async active-low reset
//   clr_i            synchronous clear of the starvation flag
//   push_i           new-request pulse for this channel
//   grant_i          arbiter selected this channel this cycle (valid, in range)
//   push_ready_o     pending count below its maximum
//   req_o            pending count non-zero
//   wait_o           cycles spent requesting without a grant (saturating)
//   starve_o         sticky starvation flag
module rr_req_chan
  import rr_pkg::*;
#(
  parameter int unsigned PENDW      = PendWDefault,
  parameter int unsigned WAIT_LIMIT = WaitLimitDefault
) (
  input  logic      clk_i,
  input  logic      rst_n_i,
  input  logic      clr_i,
  input  logic      push_i,
  input  logic      grant_i,
  output logic      push_ready_o,
  output logic      req_o,
  output wait_cnt_t wait_o,
  output logic      starve_o
);

  localparam logic [PENDW-1:0] PendMax = '1;
  localparam wait_cnt_t        WaitLim = wait_cnt_t'(WAIT_LIMIT);

  logic [PENDW-1:0] pend_q, pend_d;
  wait_cnt_t        wait_q, wait_d;
  logic             starve_q, starve_d;
  logic             push_acc, grant_acc;

  assign push_ready_o = (pend_q != PendMax);
  assign req_o        = (pend_q != '0);
  assign wait_o       = wait_q;
  assign starve_o     = starve_q;

  // A full channel drops the push; an empty channel ignores the grant.
  assign push_acc  = push_i & push_ready_o;
  assign grant_acc = grant_i & req_o;

  always_comb begin
    pend_d = pend_q;
    case ({push_acc, grant_acc})
      2'b10:   pend_d = pend_q + 1'b1;
      2'b01:   pend_d = pend_q - 1'b1;
      default: pend_d = pend_q;
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if (!req_o || grant_acc) begin
      wait_d = '0;
    end else if (wait_q != '1) begin
      wait_d = wait_q + 1'b1;
    end
  end

  // Set only on the crossing so a clear is not undone while still waiting.
  always_comb begin
    starve_d = starve_q | (wait_q == WaitLim);
    if (clr_i) starve_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pend_q   <= '0;
      wait_q   <= '0;
      starve_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      wait_q   <= wait_d;
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/rr_req_manager.sv
// Request manager sitting between clients and a round-robin arbiter.
// Tracks per-channel outstanding requests, presents a request vector to the
// arbiter, returns a one-cycle grant pulse per accepted grant, and reports
// starvation, the largest observed wait and protocol errors.
// Ports:
//   clk_i, rst_n_i   clock, async active-low reset
//   push_i           per-channel new-request pulses
//   push_ready_o     per-channel room for another request
//   req_o            per-channel request vector to the arbiter
//   req_num_i        granted channel index from the arbiter
//   req_num_val_i    req_num_i valid this cycle
//   grant_o          one-hot grant pulse back to the client
//   starve_o         sticky per-channel starvation flags
//   max_wait_o       largest wait count seen since reset/clear
//   err_o            sticky protocol error
//   clr_i            synchronous clear of starve_o, max_wait_o, err_o
module rr_req_manager
  import rr_pkg::*;
#(
  parameter int unsigned REQCNT     = ReqCntDefault,
  parameter int unsigned PENDW      = PendWDefault,
  parameter int unsigned WAIT_LIMIT = WaitLimitDefault,
  localparam int unsigned IdxW      = (REQCNT > 1) ? $clog2(REQCNT) : 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [REQCNT-1:0] push_i,
  output logic [REQCNT-1:0] push_ready_o,
  output logic [REQCNT-1:0] req_o,
  input  logic [IdxW-1:0]   req_num_i,
  input  logic              req_num_val_i,
  output logic [REQCNT-1:0] grant_o,
  output logic [REQCNT-1:0] starve_o,
  output logic [15:0]       max_wait_o,
  output logic              err_o,
  input  logic              clr_i
);

  logic [REQCNT-1:0] gnt_sel;
  logic              idx_err;
  logic [REQCNT-1:0] grant_q;
  wait_cnt_t         wait_cnt [REQCNT];
  wait_cnt_t         max_wait_q, max_wait_d;
  logic              err_q, err_d;

  always_comb begin
    gnt_sel = '0;
    idx_err = 1'b0;
    if (req_num_val_i) begin
      if (32'(req_num_i) < REQCNT) begin
        gnt_sel[req_num_i] = 1'b1;
      end else begin
        idx_err = 1'b1;
      end
    end
  end

  for (genvar i = 0; i < REQCNT; i++) begin : g_chan
    rr_req_chan #(
      .PENDW      (PENDW),
      .WAIT_LIMIT (WAIT_LIMIT)
    ) u_chan (
      .clk_i        (clk_i),
      .rst_n_i      (rst_n_i),
      .clr_i        (clr_i),
      .push_i       (push_i[i]),
      .grant_i      (gnt_sel[i]),
      .push_ready_o (push_ready_o[i]),
      .req_o        (req_o[i]),
      .wait_o       (wait_cnt[i]),
      .starve_o     (starve_o[i])
    );
  end

  always_comb begin
    max_wait_d = max_wait_q;
    for (int i = 0; i < int'(REQCNT); i++) begin
      if (wait_cnt[i] > max_wait_d) max_wait_d = wait_cnt[i];
    end
    if (clr_i) max_wait_d = '0;
  end

  // Errors: grant to an empty channel, out-of-range index, push while full.
  always_comb begin
    err_d = err_q | idx_err | (|(gnt_sel & ~req_o)) | (|(push_i & ~push_ready_o));
    if (clr_i) err_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      grant_q    <= '0;
      max_wait_q <= '0;
      err_q      <= 1'b0;
    end else begin
      grant_q    <= gnt_sel & req_o;
      max_wait_q <= max_wait_d;
      err_q      <= err_d;
    end
  end

  assign grant_o    = grant_q;
  assign max_wait_o = max_wait_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_rr_req_manager.sv
module tb_rr_req_manager;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] push = '0;
  logic [15:0] push_ready;
  logic [15:0] req;
  logic [3:0]  req_num = '0;
  logic        req_num_val = 1'b0;
  logic [15:0] grant;
  logic [15:0] starve;
  logic [15:0] max_wait;
  logic        err;
  logic        clr = 1'b0;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  rr_req_manager dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .push_i        (push),
    .push_ready_o  (push_ready),
    .req_o         (req),
    .req_num_i     (req_num),
    .req_num_val_i (req_num_val),
    .grant_o       (grant),
    .starve_o      (starve),
    .max_wait_o    (max_wait),
    .err_o         (err),
    .clr_i         (clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; holds inputs for one rising edge, returns at the next negedge.
  task automatic step(input logic [15:0] p, input logic gv, input logic [3:0] gn,
                      input logic c, input logic expg);
    push = p;
    req_num_val = gv;
    req_num = gn;
    clr = c;
    if (expg) exp_q.push_back(16'(1) << gn);
    @(negedge clk);
    push = '0;
    req_num_val = 1'b0;
    req_num = '0;
    clr = 1'b0;
  endtask

  // Monitor: every grant pulse (or missing expected pulse) is checked against the scoreboard.
  initial begin
    logic [15:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && (grant != '0 || exp_q.size() != 0)) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 16'h0000;
        check("grant_pulse", grant, e);
      end
    end
  end

  initial begin
    int unsigned model [16];
    logic [15:0] p, mreq, mrdy;
    logic        gv;
    logic [3:0]  gn;

    for (int i = 0; i < 16; i++) model[i] = 0;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("rst_req", req, 16'h0000);
    check("rst_push_ready", push_ready, 16'hFFFF);
    check("rst_grant", grant, 16'h0000);
    check("rst_starve", starve, 16'h0000);
    check("rst_max_wait", max_wait, 16'h0000);
    check("rst_err", err, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Push on first edge after release, one-cycle visibility
    step(16'h0005, 1'b0, 4'd0, 1'b0, 1'b0);
    check("push_req", req, 16'h0005);
    check("push_ready_all", push_ready, 16'hFFFF);

    // Grant channel 2: req drops in the same cycle the grant pulse appears
    step(16'h0000, 1'b1, 4'd2, 1'b0, 1'b1);
    check("grant2_req", req, 16'h0001);
    step(16'h0000, 1'b1, 4'd0, 1'b0, 1'b1);
    check("grant0_req", req, 16'h0000);
    check("no_err_yet", err, 1'b0);

    // Grant to an empty channel: no pulse, error set, clear removes it
    step(16'h0000, 1'b1, 4'd4, 1'b0, 1'b0);
    check("empty_grant_err", err, 1'b1);
    check("empty_grant_req", req, 16'h0000);
    step(16'h0000, 1'b0, 4'd0, 1'b1, 1'b0);
    check("clr_err", err, 1'b0);

    // Fill channel 3, then overflow
    for (int k = 0; k < 15; k++) step(16'h0008, 1'b0, 4'd0, 1'b0, 1'b0);
    check("full_ready", push_ready, 16'hFFF7);
    check("full_req", req, 16'h0008);
    check("full_no_err", err, 1'b0);
    step(16'h0008, 1'b0, 4'd0, 1'b0, 1'b0);
    check("overflow_err", err, 1'b1);
    check("overflow_ready", push_ready, 16'hFFF7);
    for (int k = 0; k < 14; k++) step(16'h0000, 1'b1, 4'd3, 1'b0, 1'b1);
    check("drain3_partial", req, 16'h0008);
    step(16'h0000, 1'b1, 4'd3, 1'b0, 1'b1);
    check("drain3_empty", req, 16'h0000);
    check("drain3_ready", push_ready, 16'hFFFF);
    step(16'h0000, 1'b0, 4'd0, 1'b1, 1'b0);
    check("clr_err2", err, 1'b0);

    // Simultaneous push and grant on channel 5
    step(16'h0020, 1'b0, 4'd0, 1'b0, 1'b0);
    step(16'h0020, 1'b1, 4'd5, 1'b0, 1'b1);
    check("pushgrant_req", req, 16'h0020);
    step(16'h0000, 1'b1, 4'd5, 1'b0, 1'b1);
    check("pushgrant_drain", req, 16'h0000);
    check("pushgrant_err", err, 1'b0);

    // Starvation on channel 7: wait reaches 64 after 64 idle edges, flag one edge later
    step(16'h0080, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int k = 0; k < 64; k++) step(16'h0000, 1'b0, 4'd0, 1'b0, 1'b0);
    check("starve_not_yet", starve, 16'h0000);
    step(16'h0000, 1'b0, 4'd0, 1'b0, 1'b0);
    check("starve_set", starve, 16'h0080);
    check("max_wait_ge64", 32'(max_wait >= 16'd64), 1);
    step(16'h0000, 1'b0, 4'd0, 1'b1, 1'b0);
    check("clr_starve", starve, 16'h0000);
    check("clr_max_wait", max_wait, 16'h0000);
    step(16'h0000, 1'b1, 4'd7, 1'b0, 1'b1);
    check("starve_drain", req, 16'h0000);
    step(16'h0000, 1'b0, 4'd0, 1'b1, 1'b0);

    // Mixed traffic against a pending-count model
    for (int c = 0; c < 400; c++) begin
      p = '0;
      for (int i = 0; i < 16; i++) begin
        if (model[i] < 15 && $urandom_range(0, 11) == 0) p[i] = 1'b1;
      end
      gn = 4'($urandom_range(0, 15));
      gv = (model[gn] != 0);
      step(p, gv, gn, 1'b0, gv);
      if (gv) model[gn]--;
      for (int i = 0; i < 16; i++) if (p[i]) model[i]++;
      for (int i = 0; i < 16; i++) begin
        mreq[i] = (model[i] != 0);
        mrdy[i] = (model[i] != 15);
      end
      check("traffic_req", req, mreq);
      check("traffic_ready", push_ready, mrdy);
    end
    for (int i = 0; i < 16; i++) begin
      for (int k = 0; k < 15; k++) begin
        if (model[i] != 0) begin
          step(16'h0000, 1'b1, 4'(i), 1'b0, 1'b1);
          model[i]--;
        end
      end
    end
    check("traffic_drained", req, 16'h0000);
    check("traffic_no_err", err, 1'b0);

    // Reset mid-operation discards outstanding requests
    step(16'h0003, 1'b0, 4'd0, 1'b0, 1'b0);
    check("pre_reset_req", req, 16'h0003);
    rst_n = 1'b0;
    #1;
    check("async_rst_req", req, 16'h0000);
    check("async_rst_ready", push_ready, 16'hFFFF);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step(16'h0000, 1'b0, 4'd0, 1'b0, 1'b0);
    check("post_reset_req", req, 16'h0000);
    step(16'h0002, 1'b0, 4'd0, 1'b0, 1'b0);
    check("post_reset_push", req, 16'h0002);
    step(16'h0000, 1'b1, 4'd1, 1'b0, 1'b1);
    check("post_reset_drain", req, 16'h0000);

    step(16'h0000, 1'b0, 4'd0, 1'b0, 1'b0);
    step(16'h0000, 1'b0, 4'd0, 1'b0, 1'b0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
